// File: rtl/iiitb_rtc_param.sv
// Real-time clock with a parameterised seconds divider, BCD time-of-day, validated load,
// and a latched hh:mm alarm. The display can be switched between 12-hour and 24-hour form.
module iiitb_rtc_param #(
    parameter int CLK_DIV = 100,
    parameter int DIV_W   = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_12h,
    input  logic       load,
    input  logic [7:0] ld_hr,
    input  logic [7:0] ld_min,
    input  logic [7:0] ld_sec,
    input  logic       alm_wr,
    input  logic       alm_en,
    input  logic       alm_ack,
    output logic [3:0] hrm,
    output logic [3:0] hrl,
    output logic [3:0] minm,
    output logic [3:0] minl,
    output logic [3:0] secm,
    output logic [3:0] secl,
    output logic       pm,
    output logic       sec_tick,
    output logic       day_tick,
    output logic       load_err,
    output logic       alarm
);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [7:0] hr, mn, sc, alm_hr, alm_min;
    logic [7:0] hr_n, mn_n, sc_n;
    logic       ld_ok, alm_ok, load_do, upd, match;
    logic [4:0] h_bin, h12;
    logic       pm12;

    function automatic logic bcd_ok(input logic [7:0] v, input logic [3:0] tens_max);
        return (v[3:0] <= 4'd9) && (v[7:4] <= tens_max);
    endfunction

    // Wraps to 00 once the value reaches top; otherwise a BCD +1.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        ld_ok    = bcd_ok(ld_hr, 4'd2) && (ld_hr <= 8'h23) &&
                   bcd_ok(ld_min, 4'd5) && bcd_ok(ld_sec, 4'd5);
        alm_ok   = bcd_ok(ld_hr, 4'd2) && (ld_hr <= 8'h23) && bcd_ok(ld_min, 4'd5);
        sec_tick = (div == DIV_MAX);
        load_do  = load && ld_ok;
        upd      = load_do || sec_tick;
        day_tick = sec_tick && !load_do &&
                   (hr == 8'h23) && (mn == 8'h59) && (sc == 8'h59);

        sc_n = bcd_inc(sc, 8'h59);
        mn_n = (sc == 8'h59) ? bcd_inc(mn, 8'h59) : mn;
        hr_n = ((sc == 8'h59) && (mn == 8'h59)) ? bcd_inc(hr, 8'h23) : hr;
        if (load_do) begin
            hr_n = ld_hr;
            mn_n = ld_min;
            sc_n = ld_sec;
        end

        // Compare against the value the time registers are about to take.
        match = alm_en && upd && (hr_n == alm_hr) && (mn_n == alm_min) && (sc_n == 8'h00);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div      <= '0;
            hr       <= 8'h00;
            mn       <= 8'h00;
            sc       <= 8'h00;
            alm_hr   <= 8'h00;
            alm_min  <= 8'h00;
            alarm    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            div <= upd ? '0 : div + 1'b1;
            if (upd) begin
                hr <= hr_n;
                mn <= mn_n;
                sc <= sc_n;
            end
            if (alm_wr && alm_ok) begin
                alm_hr  <= ld_hr;
                alm_min <= ld_min;
            end
            load_err <= (load && !ld_ok) || (alm_wr && !alm_ok);
            if (match)
                alarm <= 1'b1;
            else if (alm_ack || !alm_en)
                alarm <= 1'b0;
        end
    end

    always_comb begin
        h_bin = 5'(hr[7:4]) * 5'd10 + 5'(hr[3:0]);
        h12   = h_bin;
        pm12  = 1'b0;
        if (h_bin == 5'd0) begin
            h12 = 5'd12;
        end else if (h_bin >= 5'd12) begin
            pm12 = 1'b1;
            if (h_bin > 5'd12)
                h12 = h_bin - 5'd12;
        end

        if (mode_12h) begin
            hrm = (h12 >= 5'd10) ? 4'd1 : 4'd0;
            hrl = (h12 >= 5'd10) ? 4'(h12 - 5'd10) : 4'(h12);
            pm  = pm12;
        end else begin
            hrm = hr[7:4];
            hrl = hr[3:0];
            pm  = 1'b0;
        end
        minm = mn[7:4];
        minl = mn[3:0];
        secm = sc[7:4];
        secl = sc[3:0];
    end

endmodule

// File: tb/tb_iiitb_rtc_param.sv
// Directed bench for iiitb_rtc_param (CLK_DIV=4): stimulus queues expected snapshots,
// a negedge monitor pops one on every snapshot request, load_err or day_tick pulse.
module tb_iiitb_rtc_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode_12h = 1'b0, load = 1'b0, alm_wr = 1'b0, alm_en = 1'b0, alm_ack = 1'b0;
    logic [7:0] ld_hr = 8'h00, ld_min = 8'h00, ld_sec = 8'h00;
    logic [3:0] hrm, hrl, minm, minl, secm, secl;
    logic       pm, sec_tick, day_tick, load_err, alarm;

    iiitb_rtc_param #(.CLK_DIV(4), .DIV_W(24)) dut (
        .clk(clk), .rst(rst), .mode_12h(mode_12h), .load(load),
        .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec),
        .alm_wr(alm_wr), .alm_en(alm_en), .alm_ack(alm_ack),
        .hrm(hrm), .hrl(hrl), .minm(minm), .minl(minl), .secm(secm), .secl(secl),
        .pm(pm), .sec_tick(sec_tick), .day_tick(day_tick), .load_err(load_err), .alarm(alarm)
    );

    always #5 clk = ~clk;

    // Expected word: {digits[23:0], pm, sec_tick, day_tick, load_err, alarm}
    typedef struct {
        string       name;
        logic [28:0] v;
    } rec_t;

    rec_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic snap_req = 1'b0;

    function automatic void push(input string n, input logic [23:0] d, input logic p,
                                 input logic st, input logic dt, input logic le, input logic al);
        rec_t r;
        r.name = n;
        r.v    = {d, p, st, dt, le, al};
        q.push_back(r);
    endfunction

    always @(negedge clk) begin
        logic [28:0] act;
        rec_t        r;
        if (snap_req || day_tick || load_err) begin
            act = {hrm, hrl, minm, minl, secm, secl, pm, sec_tick, day_tick, load_err, alarm};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event actual %h required none", act);
            end else begin
                r = q.pop_front();
                if (act !== r.v) begin
                    errors++;
                    $display("FAIL %s actual %h required %h", r.name, act, r.v);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input string n, input logic [23:0] d, input logic p,
                        input logic st, input logic dt, input logic le, input logic al);
        push(n, d, p, st, dt, le, al);
        snap_req = 1'b1;
        @(negedge clk);
        #1;
        snap_req = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        ld_hr = h; ld_min = m; ld_sec = s; load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        cyc(); cyc();
        snap("reset_24h", 24'h000000, 0, 0, 0, 0, 0);
        mode_12h = 1'b1;
        snap("reset_12h", 24'h120000, 0, 0, 0, 0, 0);
        mode_12h = 1'b0;
        rst = 1'b1;

        for (int i = 1; i <= 16; i++) begin
            cyc();
            snap("free_run", 24'(i / 4), 0, (i % 4) == 3, 0, 0, 0);
        end

        // Midnight rollover
        do_load(8'h23, 8'h59, 8'h59);
        snap("load_235959", 24'h235959, 0, 0, 0, 0, 0);
        repeat (3) cyc();
        snap("day_tick", 24'h235959, 0, 1, 1, 0, 0);
        cyc();
        snap("rollover", 24'h000000, 0, 0, 0, 0, 0);

        // Invalid loads: divider keeps counting, time untouched
        ld_hr = 8'h24; ld_min = 8'h00; ld_sec = 8'h00; load = 1'b1;
        push("bad_hr", 24'h000000, 0, 0, 0, 1, 0);
        cyc();
        ld_hr = 8'h12; ld_min = 8'h6A; ld_sec = 8'h00;
        push("bad_min", 24'h000000, 0, 0, 0, 1, 0);
        cyc();
        load = 1'b0;
        cyc();
        snap("div_kept", 24'h000000, 0, 1, 0, 0, 0);
        cyc();
        snap("tick_after_bad", 24'h000001, 0, 0, 0, 0, 0);

        // Load coincident with a tick at 23:59:59
        do_load(8'h23, 8'h59, 8'h59);
        repeat (3) cyc();
        ld_hr = 8'h05; ld_min = 8'h06; ld_sec = 8'h07; load = 1'b1;
        snap("coinc_no_day", 24'h235959, 0, 1, 0, 0, 0);
        cyc();
        load = 1'b0;
        snap("coinc_exact", 24'h050607, 0, 0, 0, 0, 0);

        // Alarm write, invalid alarm write, match on tick, ack
        ld_hr = 8'h07; ld_min = 8'h30; alm_wr = 1'b1;
        cyc();
        ld_min = 8'h60;
        push("bad_alm", 24'h050607, 0, 0, 0, 1, 0);
        cyc();
        alm_wr = 1'b0;
        alm_en = 1'b1;
        do_load(8'h07, 8'h29, 8'h59);
        snap("pre_alarm", 24'h072959, 0, 0, 0, 0, 0);
        repeat (3) cyc();
        snap("pre_alarm_tick", 24'h072959, 0, 1, 0, 0, 0);
        cyc();
        snap("alarm_set", 24'h073000, 0, 0, 0, 0, 1);
        alm_ack = 1'b1;
        cyc();
        alm_ack = 1'b0;
        snap("alarm_ack", 24'h073000, 0, 0, 0, 0, 0);

        alm_en = 1'b0;
        do_load(8'h07, 8'h29, 8'h59);
        repeat (4) cyc();
        snap("alarm_disabled", 24'h073000, 0, 0, 0, 0, 0);

        alm_en = 1'b1;
        do_load(8'h07, 8'h29, 8'h59);
        repeat (3) cyc();
        alm_ack = 1'b1;
        cyc();
        alm_ack = 1'b0;
        snap("match_beats_ack", 24'h073000, 0, 0, 0, 0, 1);
        alm_en = 1'b0;
        cyc();
        snap("en_low_clears", 24'h073000, 0, 0, 0, 0, 0);

        // 12-hour display
        mode_12h = 1'b1;
        do_load(8'h00, 8'h15, 8'h00);
        snap("h12_0015", 24'h121500, 0, 0, 0, 0, 0);
        do_load(8'h12, 8'h00, 8'h00);
        snap("h12_1200", 24'h120000, 1, 0, 0, 0, 0);
        do_load(8'h13, 8'h05, 8'h00);
        snap("h12_1305", 24'h010500, 1, 0, 0, 0, 0);
        do_load(8'h23, 8'h45, 8'h00);
        snap("h12_2345", 24'h114500, 1, 0, 0, 0, 0);
        mode_12h = 1'b0;
        snap("h24_back", 24'h234500, 0, 0, 0, 0, 0);

        // Alarm set by a load, then async reset mid-count
        alm_en = 1'b1;
        ld_hr = 8'h10; ld_min = 8'h20; alm_wr = 1'b1;
        cyc();
        alm_wr = 1'b0;
        do_load(8'h10, 8'h20, 8'h00);
        snap("alarm_on_load", 24'h102000, 0, 0, 0, 0, 1);
        do_load(8'h10, 8'h20, 8'h30);
        cyc();
        #2 rst = 1'b0;
        snap("async_reset", 24'h000000, 0, 0, 0, 0, 0);
        cyc();
        rst = 1'b1;
        do_load(8'h00, 8'h00, 8'h00);
        snap("alm_time_cleared", 24'h000000, 0, 0, 0, 0, 1);

        repeat (2) cyc();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain actual %0d pending required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
